// File: rtl/gray_step_monitor.sv
// Receiver stage for a 4-bit Gray-coded stream: decodes each accepted word to binary,
// classifies it as a legal single step from the previous word, and tracks lock and errors.
module gray_step_monitor #(
   parameter int ERR_CNT_W = 8,
   parameter int LOCK_CNT  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 g3,
   input  logic                 g2,
   input  logic                 g1,
   input  logic                 g0,
   input  logic                 clr_err,
   output logic                 b3,
   output logic                 b2,
   output logic                 b1,
   output logic                 b0,
   output logic                 out_valid,
   output logic                 dir_up,
   output logic                 step_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HUNT   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_CNT);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

   state_t     state;
   logic [3:0] prev;
   logic [3:0] run;

   // Gray-to-binary decode kept as separate bits so each stage is a plain XOR of the one above.
   logic d3, d2, d1, d0;
   assign d3 = g3;
   assign d2 = d3 ^ g2;
   assign d1 = d2 ^ g1;
   assign d0 = d1 ^ g0;

   logic [3:0] word;
   logic       is_up;
   logic       is_down;
   logic       is_repeat;
   logic [3:0] run_inc;

   assign word      = {d3, d2, d1, d0};
   assign is_up     = (word == prev + 4'd1);
   assign is_down   = (word == prev - 4'd1);
   assign is_repeat = (word == prev);
   assign run_inc   = run + 4'd1;

   // NOTE: all state and outputs use non-blocking assignments so every register samples
   // the pre-edge values; blocking here would let later statements see half-updated state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         prev      <= 4'd0;
         run       <= 4'd0;
         {b3, b2, b1, b0} <= 4'd0;
         out_valid <= 1'b0;
         dir_up    <= 1'b1;
         step_err  <= 1'b0;
         locked    <= 1'b0;
         err_cnt   <= '0;
      end else begin
         out_valid <= in_valid;
         step_err  <= 1'b0;
         if (clr_err) begin
            err_cnt <= '0;
         end

         if (in_valid) begin
            {b3, b2, b1, b0} <= word;
            prev             <= word;

            if (state == EMPTY) begin
               state <= HUNT;
               run   <= 4'd0;
            end else if (is_up || is_down) begin
               dir_up <= is_up;
               if (state == HUNT) begin
                  run <= run_inc;
                  if (run_inc == LOCK_TARGET) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
            end else if (!is_repeat) begin
               // Illegal step: resynchronise to the new word and start hunting again.
               step_err <= 1'b1;
               run      <= 4'd0;
               state    <= HUNT;
               locked   <= 1'b0;
               if (clr_err) begin
                  err_cnt <= ERR_CNT_W'(1);
               end else if (err_cnt != ERR_MAX) begin
                  err_cnt <= err_cnt + ERR_CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Scoreboard bench for gray_step_monitor: a step-level reference model predicts each
// output cycle into a queue, and an independent monitor compares what the DUT presents.
module tb_gray_step_monitor;

   localparam int ERR_CNT_W = 2;
   localparam int LOCK_CNT  = 2;
   localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic g3, g2, g1, g0;
   logic clr_err;
   logic b3, b2, b1, b0;
   logic out_valid;
   logic dir_up;
   logic step_err;
   logic locked;
   logic [ERR_CNT_W-1:0] err_cnt;

   gray_step_monitor #(
      .ERR_CNT_W(ERR_CNT_W),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .g3       (g3),
      .g2       (g2),
      .g1       (g1),
      .g0       (g0),
      .clr_err  (clr_err),
      .b3       (b3),
      .b2       (b2),
      .b1       (b1),
      .b0       (b0),
      .out_valid(out_valid),
      .dir_up   (dir_up),
      .step_err (step_err),
      .locked   (locked),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      bit         ov;
      logic [3:0] b;
      bit         dir;
      bit         serr;
      bit         lk;
      int         err;
   } exp_t;

   exp_t exp_q[$];

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   // Reference model: tracks the stream in terms of values and legal-step streaks.
   bit         m_have;
   logic [3:0] m_prev;
   int         m_streak;
   bit         m_dir;
   bit         m_locked;
   int         m_err;

   task automatic model_reset();
      m_have   = 0;
      m_prev   = 4'd0;
      m_streak = 0;
      m_dir    = 1;
      m_locked = 0;
      m_err    = 0;
   endtask

   task automatic drive(input bit r, input bit v, input logic [3:0] bin, input bit clr);
      exp_t       e;
      logic [3:0] gray;
      int         delta;
      bit         bad;
      @(posedge clk);
      #1;
      gray = bin ^ (bin >> 1);
      rst_n    = r;
      in_valid = v;
      {g3, g2, g1, g0} = gray;
      clr_err  = clr;

      if (!r) begin
         model_reset();
         e = '{cyc: cyc + 1, ov: 0, b: 4'd0, dir: 1, serr: 0, lk: 0, err: 0};
         exp_q.push_back(e);
         return;
      end

      bad = 0;
      if (v) begin
         if (!m_have) begin
            m_have   = 1;
            m_streak = 0;
         end else begin
            delta = (int'(bin) - int'(m_prev) + 16) % 16;
            if (delta == 1) begin
               m_dir = 1;
               m_streak++;
            end else if (delta == 15) begin
               m_dir = 0;
               m_streak++;
            end else if (delta != 0) begin
               bad      = 1;
               m_streak = 0;
            end
            if (m_streak > 100) m_streak = 100;
         end
         m_locked = (m_streak >= LOCK_CNT);
         m_prev   = bin;
      end

      if (clr) m_err = bad ? 1 : 0;
      else if (bad && m_err < ERR_MAX) m_err++;

      if (v) begin
         e = '{cyc: cyc + 1, ov: 1, b: bin, dir: m_dir, serr: bad, lk: m_locked, err: m_err};
         exp_q.push_back(e);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("out_valid", out_valid, e.ov);
            check("b",         {b3, b2, b1, b0}, e.b);
            check("dir_up",    dir_up, e.dir);
            check("step_err",  step_err, e.serr);
            check("locked",    locked, e.lk);
            check("err_cnt",   err_cnt, e.err);
         end else begin
            check("idle_out_valid", out_valid, 0);
            check("idle_step_err",  step_err, 0);
         end
      end
   end

   initial begin : stimulus
      logic [3:0] seq_up[4]   = '{4'd0, 4'd1, 4'd2, 4'd3};
      logic [3:0] seq_dn[4]   = '{4'd1, 4'd0, 4'd15, 4'd14};
      logic [3:0] seq_lk[4]   = '{4'd4, 4'd5, 4'd7, 4'd8};
      logic [3:0] seq_rep[4]  = '{4'd3, 4'd3, 4'd3, 4'd4};
      logic [3:0] seq_sat[5]  = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd3};
      logic [3:0] nxt;
      int         pick;

      rst_n = 1'b0; in_valid = 1'b0; clr_err = 1'b0;
      {g3, g2, g1, g0} = 4'd0;
      model_reset();

      drive(0, 1, 4'd9, 0);
      drive(0, 0, 4'd0, 0);
      foreach (seq_up[i])  drive(1, 1, seq_up[i], 0);
      foreach (seq_dn[i])  drive(1, 1, seq_dn[i], 0);
      foreach (seq_lk[i])  drive(1, 1, seq_lk[i], 0);
      drive(1, 0, 4'd0, 0);

      drive(0, 0, 4'd0, 0);
      foreach (seq_rep[i]) drive(1, 1, seq_rep[i], 0);
      drive(1, 1, 4'd5, 0);

      foreach (seq_sat[i]) drive(1, 1, seq_sat[i], 0);
      drive(1, 1, 4'd9, 1);
      drive(1, 1, 4'd10, 0);
      drive(1, 0, 4'd0, 1);
      drive(1, 1, 4'd11, 0);

      drive(0, 1, 4'd12, 0);
      drive(1, 1, 4'd6, 0);
      drive(1, 1, 4'd7, 0);

      for (int n = 0; n < 3000; n++) begin
         pick = $urandom_range(0, 99);
         if (pick < 60) nxt = ($urandom_range(0, 1) != 0) ? m_prev + 4'd1 : m_prev - 4'd1;
         else if (pick < 75) nxt = m_prev;
         else nxt = 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0), nxt,
               ($urandom_range(0, 24) == 0));
      end

      drive(1, 0, 4'd0, 0);
      drive(1, 0, 4'd0, 0);
      drive(1, 0, 4'd0, 0);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gray_step_monitor.md
# gray_step_monitor

Registered receiver stage directly downstream of the 4-bit binary-to-Gray converter. It samples a Gray code word on each valid cycle and decodes it to binary. It checks that every new word is a legal single step (+1, −1 or repeat, modulo 16) from the previous one. It reports direction, lock status and a saturating error count, so Gray-coded position or count sources can be trusted by later logic.

## Interface
- ERR_CNT_W, 8, width of the saturating error counter
- LOCK_CNT, 2, consecutive legal steps (±1) required to assert `locked`; legal range 1..15
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  g3..g0 are valid this cycle
- g3, g2, g1, g0  input  1 each  Gray code word, g3 = MSB
- clr_err  input  1  clear error counter
- b3, b2, b1, b0  output  1 each  registered binary decode of the last accepted word
- out_valid  output  1  one-cycle pulse per accepted word
- dir_up  output  1  direction of last legal ±1 step (1 = up)
- step_err  output  1  one-cycle pulse: accepted word is an illegal step
- locked  output  1  LOCK_CNT consecutive legal steps seen since last error or reset
- err_cnt  output  ERR_CNT_W  saturating count of step_err events

## Operation
- Decode: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0. Combinational on the input, then registered.
- Stored state:
  - prev: last accepted binary value, 4 bits
  - run: count of consecutive legal steps
  - FSM state
- Step classification, for an accepted word with value new, against prev:
  - new == prev: REPEAT
  - new == prev+1 mod 16: UP
  - new == prev−1 mod 16: DOWN
  - anything else: ERR. This includes single-bit Gray changes that are not sequence-adjacent, e.g. 0000→0100.
- FSM states: EMPTY, HUNT, LOCKED.
  - EMPTY + in_valid → HUNT. run=0, no classification, no step_err.
  - HUNT + UP/DOWN → run++. When run reaches LOCK_CNT → LOCKED.
  - HUNT + ERR → run=0, stay in HUNT.
  - LOCKED + UP/DOWN → stay in LOCKED.
  - LOCKED + ERR → HUNT, run=0.
  - REPEAT in any state: no change to run, state or dir_up.
- dir_up: set to 1 on UP, 0 on DOWN, otherwise held.
- prev: updated on every accepted word, including ERR. Resynchronisation is to the new value.
- err_cnt: +1 on ERR and saturates at 2^ERR_CNT_W−1.
  - clr_err alone: err_cnt → 0.
  - clr_err in the same cycle as ERR: err_cnt → 1, so the event is not lost.
- Wrap-around is legal: 15→0 is UP and 0→15 is DOWN.
- No backpressure; an input is accepted on every cycle that in_valid=1.

## Timing
- Latency 1 cycle. A word sampled at edge N produces b3..b0, out_valid, step_err, dir_up, locked and err_cnt all updated at edge N+1.
- Back-to-back in_valid at full clock rate is supported. out_valid is high on each corresponding cycle.
- out_valid and step_err are single-cycle pulses. With in_valid=0, both are 0 next cycle and all other outputs hold.
- locked asserts in the same cycle as the out_valid of the LOCK_CNT-th legal step. It deasserts in the same cycle as the step_err that breaks lock.
- Reset values: b3..b0=0, out_valid=0, dir_up=1, step_err=0, locked=0, err_cnt=0, state=EMPTY, run=0, prev=0.
- Reset has priority over everything. An in_valid word present while rst_n=0 is dropped.
- Reset mid-stream: the first word after reset re-enters via EMPTY and is never flagged as an error.

## Test plan
- Reset then stream Gray 0000,0001,0011,0010 (binary 0..3) → out_valid each cycle at 1-cycle latency. b=0,1,2,3. locked=1 with the 3rd word's output. dir_up=1, err_cnt=0.
- Count down across wrap: binary 1,0,15,14 (Gray 0001,0000,1000,1001) → dir_up=0 from the 2nd word, no step_err, locked=1.
- Locked at binary 5, then Gray 0100 (binary 7) → step_err=1 for one cycle, locked=0, err_cnt=1. Next binary 8 (Gray 1100) counts as a legal UP from 7.
- Repeat words: binary 3,3,3,4 with LOCK_CNT=2 from EMPTY → no error. Lock is reached only after legal steps, never counted from repeats.
- Force err_cnt to saturate with ERR_CNT_W=2 (4 errors) → err_cnt holds at 3. Then clr_err together with an ERR → err_cnt=1. clr_err alone → err_cnt=0.
- Assert rst_n=0 for one cycle mid-stream with in_valid=1 → all outputs at reset values next edge. The dropped word produces no out_valid. The following word gives out_valid with step_err=0.
